// File: rtl/cmd_scheduler.sv
// Command byte scheduler: buffers SPI command bytes in a FIFO and releases them to the DSP engine
// one at a time, holding off during a guard window after sample_ready and spacing issued bytes.
module cmd_scheduler #(
  parameter int unsigned FifoDepth   = 32,
  parameter int unsigned GuardCycles = 16,
  parameter int unsigned GapCycles   = 4,
  parameter int unsigned CountWidth  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            in_byte_i,
  input  logic                  in_valid_i,
  input  logic                  sample_ready_i,
  input  logic                  engine_ready_i,
  input  logic                  clear_overflow_i,
  output logic [7:0]            out_byte_o,
  output logic                  out_valid_o,
  output logic [CountWidth-1:0] fifo_count_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned MaxCnt = (GuardCycles > GapCycles) ? GuardCycles : GapCycles;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0]       GuardLoad  = CntW'(GuardCycles - 1);
  localparam logic [CntW-1:0]       GapLoad    = (GapCycles == 0) ? '0 : CntW'(GapCycles - 1);
  localparam logic [CountWidth-1:0] DepthCount = CountWidth'(FifoDepth);
  localparam bit                    HasGap     = (GapCycles != 0);

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StGap
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]         wptr_q, wptr_d;
  logic [PtrW-1:0]         rptr_q, rptr_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              out_byte_q, out_byte_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              mem_q [FifoDepth];

  logic full;
  logic push;
  logic drop;
  logic issue;

  // Fullness is judged on the registered count, so a pop never frees a slot for a same-cycle write.
  assign full  = (count_q == DepthCount);
  assign push  = in_valid_i & ~full;
  assign drop  = in_valid_i & full;
  assign issue = (state_q == StIdle) & ~sample_ready_i & engine_ready_i & (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (sample_ready_i) begin
          state_d = StGuard;
          cnt_d   = GuardLoad;
        end else if (issue && HasGap) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end
      end
      StGuard: begin
        if (sample_ready_i) begin
          cnt_d = GuardLoad;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        // A new sample always opens a full guard window, cutting the gap short.
        if (sample_ready_i) begin
          state_d = StGuard;
          cnt_d   = GuardLoad;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wptr_d      = wptr_q + PtrW'(push);
    rptr_d      = rptr_q + PtrW'(issue);
    count_d     = count_q + CountWidth'(push) - CountWidth'(issue);
    out_valid_d = issue;
    out_byte_d  = issue ? mem_q[rptr_q] : out_byte_q;
    ovf_d       = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem_q[wptr_q] <= in_byte_i;
    end
  end

  assign out_byte_o   = out_byte_q;
  assign out_valid_o  = out_valid_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != StIdle) | (count_q != '0);

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a blocking-window queue model.
module tb_cmd_scheduler;
  localparam int FD    = 32;
  localparam int GUARD = 16;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       sample_ready;
  logic       engine_ready;
  logic       clear_overflow;
  logic [7:0] out_byte;
  logic       out_valid;
  logic [5:0] fifo_count;
  logic       overflow;
  logic       busy;

  always #5 clk = ~clk;

  cmd_scheduler #(
    .FifoDepth  (FD),
    .GuardCycles(GUARD),
    .GapCycles  (GAP),
    .CountWidth (6)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_byte_i       (in_byte),
    .in_valid_i      (in_valid),
    .sample_ready_i  (sample_ready),
    .engine_ready_i  (engine_ready),
    .clear_overflow_i(clear_overflow),
    .out_byte_o      (out_byte),
    .out_valid_o     (out_valid),
    .fifo_count_o    (fifo_count),
    .overflow_o      (overflow),
    .busy_o          (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  // Model: a byte queue plus the last edge (inclusive) at which the scheduler is still blocked.
  // A byte may go out no earlier than two edges past that point.
  logic [7:0] mq[$];
  int         blk    = -100;
  logic       m_ovf  = 1'b0;
  logic       m_vld  = 1'b0;
  logic [7:0] m_byte = 8'h00;

  int         iss_cyc[$];
  logic [7:0] iss_byte[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic iss;
    logic drp;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      blk    = -100;
      m_ovf  = 1'b0;
      m_vld  = 1'b0;
      m_byte = 8'h00;
      return;
    end
    drp   = in_valid && (mq.size() == FD);
    iss   = !sample_ready && engine_ready && (mq.size() > 0) && (cyc >= blk + 2);
    m_vld = iss;
    if (iss) m_byte = mq.pop_front();
    if (in_valid && !drp) mq.push_back(in_byte);
    if (drp) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    if (sample_ready) blk = cyc + GUARD - 1;
    else if (iss) blk = cyc + GAP - 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(m_vld));
      chk("out_byte", int'(out_byte), int'(m_byte));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("busy", int'(busy), int'((cyc <= blk) || (mq.size() != 0)));
      if (out_valid === 1'b1) begin
        iss_cyc.push_back(cyc);
        iss_byte.push_back(out_byte);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    in_valid       = 1'b0;
    sample_ready   = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
  endtask

  task automatic clr_log();
    iss_cyc.delete();
    iss_byte.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; sample_ready = 1'b0;
    engine_ready = 1'b0; clear_overflow = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Reset state and minimum latency.
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_byte", int'(out_byte), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    engine_ready = 1'b1;
    wr(8'hA5);
    chk("t1_count_after_write", int'(fifo_count), 1);
    tick();
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_out_byte", int'(out_byte), 8'hA5);
    chk("t1_count", int'(fifo_count), 0);

    // Back-to-back writes issued with gap spacing.
    idle(10);
    clr_log();
    wr(8'h01); wr(8'h02); wr(8'h03);
    idle(20);
    chk("t2_issue_count", iss_cyc.size(), 3);
    if (iss_cyc.size() == 3) begin
      chk("t2_byte0", int'(iss_byte[0]), 1);
      chk("t2_byte1", int'(iss_byte[1]), 2);
      chk("t2_byte2", int'(iss_byte[2]), 3);
      chk("t2_space01", iss_cyc[1] - iss_cyc[0], 5);
      chk("t2_space12", iss_cyc[2] - iss_cyc[1], 5);
    end

    // Guard window, then a guard retrigger.
    idle(10);
    engine_ready = 1'b0;
    wr(8'h11); wr(8'h12);
    tick();
    clr_log();
    sample_ready = 1'b1; engine_ready = 1'b1;
    tick();
    s = cyc;
    idle(30);
    chk("t3a_issue_count", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 1) chk("t3a_first_delay", iss_cyc[0] - s, 17);

    engine_ready = 1'b0;
    wr(8'h21); wr(8'h22);
    tick();
    clr_log();
    sample_ready = 1'b1; engine_ready = 1'b1;
    tick();
    s = cyc;
    idle(9);
    sample_ready = 1'b1;
    tick();
    idle(30);
    chk("t3b_issue_count", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 1) chk("t3b_first_delay", iss_cyc[0] - s, 27);

    // Fill past full, clear overflow, then pop and write together on full and non-full FIFOs.
    engine_ready = 1'b0;
    for (int i = 0; i < 33; i++) wr(8'(i));
    chk("t4_count_full", int'(fifo_count), 32);
    chk("t4_overflow", int'(overflow), 1);
    idle(2);
    clear_overflow = 1'b1;
    tick();
    chk("t4_overflow_cleared", int'(overflow), 0);
    clr_log();
    engine_ready = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
    tick();
    chk("t5_full_pop_valid", int'(out_valid), 1);
    chk("t5_full_pop_count", int'(fifo_count), 31);
    chk("t5_full_pop_overflow", int'(overflow), 1);
    idle(4);
    in_valid = 1'b1; in_byte = 8'h77;
    tick();
    chk("t5_pop_write_valid", int'(out_valid), 1);
    chk("t5_pop_write_count", int'(fifo_count), 31);
    idle(200);
    chk("t4_issue_count", iss_byte.size(), 33);
    if (iss_byte.size() == 33) begin
      for (int i = 0; i < 32; i++) chk($sformatf("t4_order_%0d", i), int'(iss_byte[i]), i);
      chk("t5_late_write", int'(iss_byte[32]), 8'h77);
    end
    chk("t4_drained", int'(fifo_count), 0);

    // Reset in the middle of a gap with bytes still queued.
    engine_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    tick();
    engine_ready = 1'b1;
    tick();
    chk("t6_count_before_reset", int'(fifo_count), 5);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_count", int'(fifo_count), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    clr_log();
    idle(20);
    chk("t6_no_issue", iss_cyc.size(), 0);

    // Random traffic: heavy then light load, rare resets and samples.
    for (int i = 0; i < 4000; i++) begin
      rst_n          = ($urandom_range(0, 499) != 0);
      in_valid       = ($urandom_range(0, 99) < ((i < 2000) ? 45 : 12));
      in_byte        = 8'($urandom);
      sample_ready   = ($urandom_range(0, 99) < 2);
      engine_ready   = ($urandom_range(0, 99) < 60);
      clear_overflow = ($urandom_range(0, 99) < 3);
      tick();
    end
    rst_n = 1'b1;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
